// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - decode/controller to execute-stage signal bundle
interface ex_stage_if;
  logic        stall;
  logic        flush;
  logic        int_detect;

  logic [29:0] id_pc;
  logic        id_en;
  logic [3:0]  id_alu_op;
  logic [31:0] id_alu_in_0;
  logic [31:0] id_alu_in_1;
  logic        id_br_flag;
  logic [1:0]  id_mem_op;
  logic [31:0] id_mem_wr_data;
  logic [1:0]  id_ctrl_op;
  logic [4:0]  id_dst_addr;
  logic        id_gpr_we_;
  logic [2:0]  id_exp_code;

  logic        busy;
  logic [31:0] fwd_data;
  logic [29:0] ex_pc;
  logic        ex_en;
  logic        ex_br_flag;
  logic [1:0]  ex_mem_op;
  logic [31:0] ex_mem_wr_data;
  logic [1:0]  ex_ctrl_op;
  logic [4:0]  ex_dst_addr;
  logic        ex_gpr_we_;
  logic [2:0]  ex_exp_code;
  logic [31:0] ex_out;

  modport master (
    output stall, flush, int_detect,
    output id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_br_flag,
    output id_mem_op, id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_, id_exp_code,
    input  busy, fwd_data,
    input  ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op,
    input  ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out
  );

  modport slave (
    input  stall, flush, int_detect,
    input  id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_br_flag,
    input  id_mem_op, id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_, id_exp_code,
    output busy, fwd_data,
    output ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op,
    output ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out
  );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, overflow, forwarding, ex register; EX_MUL_EN adds the iterative multiplier
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input logic       clk,
  input logic       reset,
  ex_stage_if.slave bus
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_ADDS = 4'd4;
  localparam logic [3:0] OP_ADDU = 4'd5;
  localparam logic [3:0] OP_SUBS = 4'd6;
  localparam logic [3:0] OP_SUBU = 4'd7;
  localparam logic [3:0] OP_SHRL = 4'd8;
  localparam logic [3:0] OP_SHLL = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  localparam logic [2:0] EXP_UNDEF = 3'd2;
  localparam logic [2:0] EXP_OVF   = 3'd3;

  typedef struct packed {
    logic [29:0] pc;
    logic        en;
    logic        br_flag;
    logic [1:0]  mem_op;
    logic [31:0] mem_wr_data;
    logic [1:0]  ctrl_op;
    logic [4:0]  dst_addr;
    logic        gpr_we_;
    logic [2:0]  exp_code;
    logic [31:0] out;
  } ex_reg_t;

  localparam ex_reg_t EX_BUBBLE = '{
    pc: 30'd0, en: 1'b0, br_flag: 1'b0, mem_op: 2'd0, mem_wr_data: 32'd0,
    ctrl_op: 2'd0, dst_addr: 5'd0, gpr_we_: 1'b1, exp_code: 3'd0, out: 32'd0
  };

  logic [31:0] in_0;
  logic [31:0] in_1;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] alu_res;
  logic        ovf;
  logic        busy;
  logic        mul_done;
  logic        mul_undef;
  logic [31:0] mul_res;
  logic        hold;
  ex_reg_t     ex_d;
  ex_reg_t     ex_q;

  assign in_0 = bus.id_alu_in_0;
  assign in_1 = bus.id_alu_in_1;
  assign sum  = in_0 + in_1;
  assign diff = in_0 - in_1;

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_e;

  mul_state_e  state_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] acc_q;
  logic [4:0]  count_q;
  logic        mul_req;

  assign mul_req   = bus.id_en & (bus.id_alu_op == OP_MUL) & ~bus.stall & ~bus.flush;
  // busy rises in the request cycle itself so the controller freezes IF/ID at once
  assign busy      = ((state_q == MUL_IDLE) & mul_req) | (state_q == MUL_RUN);
  assign mul_done  = (state_q == MUL_DONE);
  assign mul_res   = acc_q;
  assign mul_undef = 1'b0;

  // Shift-add sequencer: one partial product per RUN cycle, DONE waits out any stall
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MUL_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        MUL_IDLE: begin
          if (mul_req) begin
            mcand_q  <= in_0;
            mplier_q <= in_1;
            acc_q    <= '0;
            count_q  <= '0;
            state_q  <= MUL_RUN;
          end
        end
        MUL_RUN: begin
          if (bus.flush) begin
            state_q <= MUL_IDLE;
          end else begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 5'd1;
            if (count_q == 5'(MUL_CYCLES - 1)) state_q <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          if (bus.flush || !bus.stall) state_q <= MUL_IDLE;
        end
        default: state_q <= MUL_IDLE;
      endcase
    end
  end
`else
  logic unused_mul_cycles;

  assign busy              = 1'b0;
  assign mul_done          = 1'b0;
  assign mul_res           = '0;
  assign mul_undef         = (bus.id_alu_op == OP_MUL);
  assign unused_mul_cycles = (MUL_CYCLES == 32);
`endif

  // ALU result and signed-overflow detection (sign-bit form)
  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (bus.id_alu_op)
      OP_NOP:  alu_res = '0;
      OP_AND:  alu_res = in_0 & in_1;
      OP_OR:   alu_res = in_0 | in_1;
      OP_XOR:  alu_res = in_0 ^ in_1;
      OP_ADDS: begin
        alu_res = sum;
        ovf     = (in_0[31] == in_1[31]) & (sum[31] != in_0[31]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUBS: begin
        alu_res = diff;
        ovf     = (in_0[31] != in_1[31]) & (diff[31] != in_0[31]);
      end
      OP_SUBU: alu_res = diff;
      OP_SHRL: alu_res = in_0 >> in_1[4:0];
      OP_SHLL: alu_res = in_0 << in_1[4:0];
      OP_MUL:  alu_res = mul_done ? mul_res : '0;
      default: alu_res = '0;
    endcase
  end

  assign bus.fwd_data = alu_res;
  assign bus.busy     = busy;

  // A flush aborting a running multiply must still bubble the register, so busy only holds without flush
  assign hold = bus.stall | (busy & ~bus.flush);

  // Next ex register value: hold, bubble, or load with exception squashing
  always_comb begin
    ex_d = ex_q;
    if (hold) begin
      ex_d = ex_q;
    end else if (bus.flush || bus.int_detect) begin
      ex_d = EX_BUBBLE;
    end else begin
      ex_d.pc          = bus.id_pc;
      ex_d.en          = bus.id_en;
      ex_d.br_flag     = bus.id_br_flag;
      ex_d.mem_op      = bus.id_mem_op;
      ex_d.mem_wr_data = bus.id_mem_wr_data;
      ex_d.ctrl_op     = bus.id_ctrl_op;
      ex_d.dst_addr    = bus.id_dst_addr;
      ex_d.gpr_we_     = bus.id_gpr_we_;
      ex_d.exp_code    = bus.id_exp_code;
      ex_d.out         = alu_res;
      if (ovf) begin
        ex_d.mem_op   = 2'd0;
        ex_d.gpr_we_  = 1'b1;
        ex_d.exp_code = EXP_OVF;
      end else if (mul_undef) begin
        ex_d.mem_op   = 2'd0;
        ex_d.gpr_we_  = 1'b1;
        ex_d.exp_code = EXP_UNDEF;
        ex_d.out      = '0;
      end
    end
  end

  // ex pipeline register
  always_ff @(posedge clk) begin
    if (reset) ex_q <= EX_BUBBLE;
    else       ex_q <= ex_d;
  end

  assign bus.ex_pc          = ex_q.pc;
  assign bus.ex_en          = ex_q.en;
  assign bus.ex_br_flag     = ex_q.br_flag;
  assign bus.ex_mem_op      = ex_q.mem_op;
  assign bus.ex_mem_wr_data = ex_q.mem_wr_data;
  assign bus.ex_ctrl_op     = ex_q.ctrl_op;
  assign bus.ex_dst_addr    = ex_q.dst_addr;
  assign bus.ex_gpr_we_     = ex_q.gpr_we_;
  assign bus.ex_exp_code    = ex_q.exp_code;
  assign bus.ex_out         = ex_q.out;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits between the decode stage and mem_stage.
- Performs ALU operations on the operands decoded by the decode stage.
- Detects signed overflow and produces the forwarding value.
- Registers every ex_* control/data field consumed by mem_stage.
- Optionally hosts an iterative multiplier that raises busy to the pipeline controller.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations for MUL; legal values 32 only (fixed-width datapath).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold ex pipeline register
- flush  in  1  convert ex pipeline register to bubble
- int_detect  in  1  interrupt taken; next register load becomes bubble
- id_pc  in  30  word PC of decoded insn
- id_en  in  1  decoded insn valid
- id_alu_op  in  4  ALU opcode
- id_alu_in_0  in  32  operand 0
- id_alu_in_1  in  32  operand 1
- id_br_flag  in  1  branch flag
- id_mem_op  in  2  memory op (0 = NOP)
- id_mem_wr_data  in  32  store data
- id_ctrl_op  in  2  control op
- id_dst_addr  in  5  destination GPR
- id_gpr_we_  in  1  GPR write enable, active-low
- id_exp_code  in  3  exception code from decode
- busy  out  1  multiplier in progress; controller stalls IF/ID
- fwd_data  out  32  combinational ALU result for forwarding
- ex_pc  out  30  registered PC
- ex_en  out  1  registered valid
- ex_br_flag  out  1  registered branch flag
- ex_mem_op  out  2  registered memory op
- ex_mem_wr_data  out  32  registered store data
- ex_ctrl_op  out  2  registered control op
- ex_dst_addr  out  5  registered destination
- ex_gpr_we_  out  1  registered write enable, active-low
- ex_exp_code  out  3  registered exception code
- ex_out  out  32  registered ALU result

Behaviour:
- ALU opcodes, all 32-bit, results wrap mod 2^32:
  - 0 NOP: out = 0
  - 1 AND, 2 OR, 3 XOR
  - 4 ADDS, 5 ADDU, 6 SUBS, 7 SUBU
  - 8 SHRL: in_0 >> in_1[4:0], logical
  - 9 SHLL: in_0 << in_1[4:0]
  - 10 MUL: low 32 bits of the product
  - 11–15: undefined
- Overflow: set on ADDS when the operand signs are equal and the result sign differs. Set on SUBS when the operand signs differ and the result sign differs from in_0. Never set on ADDU/SUBU.
- Exception codes: 0 none, 1 ext int, 2 undef insn, 3 overflow.
- fwd_data is combinational: ALU result, or the multiplier result in the DONE state.
- Reset values, synchronous: all ex_* outputs 0 except ex_gpr_we_ = 1. busy = 0. FSM = IDLE.
- Register update priority per clk edge:
  1. reset
  2. stall or busy: hold all fields
  3. flush or int_detect: bubble (reset values)
  4. otherwise load
- On load with overflow: ex_en = id_en, ex_mem_op = 0, ex_gpr_we_ = 1, ex_exp_code = 3. All other fields load normally.
- On a normal load, ex_out receives the ALU result. All id_* fields load into their ex_* counterparts.
- Latency: 1 cycle id→ex for all ops except MUL.
- MUL FSM, states IDLE, RUN, DONE:
  - IDLE: a MUL request is id_en & alu_op==10 & !stall & !flush. On a request, latch the operands, clear count and accumulator, go to RUN. busy = 1 combinationally in this cycle.
  - RUN: busy = 1. Each cycle: if multiplier bit0 is set, add the multiplicand to the accumulator; then shift the multiplicand left 1 and the multiplier right 1; count++. When count == MUL_CYCLES-1, go to DONE after this cycle. RUN lasts exactly 32 cycles.
  - DONE: busy = 0. The register loads the held id_* MUL insn with ex_out = product; go to IDLE. If stall, remain in DONE with busy = 0. A MUL request is ignored in DONE.
- MUL timing: request in cycle 0 → busy high cycles 0..32 → ex_out valid in cycle 34.
- flush or reset during RUN/DONE: abort to IDLE, busy = 0 next cycle. The register bubbles on flush.
- Back-to-back MULs: the second MUL starts only from IDLE, the cycle after DONE.
- A MUL with id_en = 0 never starts the FSM.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: multiplier FSM, busy and opcode 10 are implemented as above.
- Undefined: no FSM; busy is tied to 0. Opcode 10 is treated as undefined: register loads ex_exp_code = 2, ex_mem_op = 0, ex_gpr_we_ = 1, ex_out = 0.

Test Plan:
- ADDU 0xFFFFFFFF + 1, dst 3, we_ = 0 → next cycle ex_out = 0, ex_exp_code = 0, ex_gpr_we_ = 0, ex_dst_addr = 3.
- ADDS 0x7FFFFFFF + 1 → ex_exp_code = 3, ex_gpr_we_ = 1, ex_mem_op = 0, ex_en = 1.
- SHRL 0x80000000 by in_1 = 0x21 → ex_out = 0x40000000. Apply stall for 2 cycles with new id_* → ex_* unchanged. Then flush → ex_en = 0, ex_gpr_we_ = 1.
- EX_MUL_EN defined: MUL 0x00010003 × 0x00020005 → busy high 33 cycles, ex_out = 0x000B000F at cycle 34. Repeat with flush at RUN cycle 10 → busy low next cycle, ex_en = 0.
- EX_MUL_EN undefined: MUL → ex_exp_code = 2, busy stays 0.
- Assert reset during RUN, then release → all outputs at reset values, busy = 0. A fresh ADDU 2+3 gives ex_out = 5 one cycle later.
